// File: rtl/timer_irq_device_if.sv
// ============================================================================
// Module   : timer_irq_device_if
// Brief    : Bridge-side register bus and interrupt line of the countdown timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_irq_device_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       addr;
    logic             we;
    logic [CNT_W-1:0] wdata;
    logic [CNT_W-1:0] rdata;
    logic             irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

`default_nettype wire

// File: rtl/timer_irq_device.sv
// ============================================================================
// Module   : timer_irq_device
// Brief    : Memory-mapped countdown timer raising a maskable one-shot or
//            auto-reload interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_irq_device #(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    timer_irq_device_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_preset = 2'd1;
    localparam logic [1:0] c_addr_count  = 2'd2;
    localparam logic [1:0] c_mode_reload = 2'b01;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_en;
    logic             w_en_nxt;
    logic [1:0]       r_mode;
    logic             r_im;
    logic             r_flag;
    logic             w_flag_nxt;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_ctrl_wr;
    logic             w_preset_wr;

    assign w_ctrl_wr   = bus.we && (bus.addr == c_addr_ctrl);
    assign w_preset_wr = bus.we && (bus.addr == c_addr_preset);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_en     <= 1'b0;
            r_mode   <= 2'b00;
            r_im     <= 1'b0;
            r_flag   <= 1'b0;
            r_preset <= PRESET_RST;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= w_en_nxt;
            r_flag  <= w_flag_nxt;
            r_count <= w_count_nxt;
            if (w_ctrl_wr) begin
                r_mode <= bus.wdata[2:1];
                r_im   <= bus.wdata[3];
            end
            if (w_preset_wr) begin
                r_preset <= bus.wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = r_en;
        w_flag_nxt  = r_flag;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_flag_nxt  = 1'b0;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > CNT_W'(1)) begin
                    w_count_nxt = r_count - CNT_W'(1);
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                w_flag_nxt = 1'b1;
                if (r_mode == c_mode_reload) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A CTRL write overrides whatever the state machine did to EN and the flag
        if (w_ctrl_wr) begin
            w_en_nxt   = bus.wdata[0];
            w_flag_nxt = 1'b0;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            c_addr_ctrl:   bus.rdata = {{(CNT_W-4){1'b0}}, r_im, r_mode, r_en};
            c_addr_preset: bus.rdata = r_preset;
            c_addr_count:  bus.rdata = r_count;
            default:       bus.rdata = '0;
        endcase
    end

    assign bus.irq = r_im & r_flag;

endmodule

`default_nettype wire

// File: tb/tb_timer_irq_device.sv
// ============================================================================
// Module   : tb_timer_irq_device
// Brief    : Self-checking bench for timer_irq_device against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_irq_device;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset;

    timer_irq_device_if #(.CNT_W(CNT_W)) bus ();

    timer_irq_device #(
        .CNT_W      (CNT_W),
        .PRESET_RST ('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: register file plus a run described by three flags
    // (reload due, counting, expiry due); idle is none of them.
    bit          m_en, m_im, m_flag, m_ldpend, m_counting, m_expire;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;

    task automatic check_value(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_step(bit rst_n, bit w, logic [1:0] a, logic [31:0] d);
        if (!rst_n) begin
            m_en = 0; m_im = 0; m_flag = 0; m_mode = 2'b00;
            m_preset = 32'd0; m_count = 32'd0;
            m_ldpend = 0; m_counting = 0; m_expire = 0;
            return;
        end
        if (m_expire) begin
            m_expire = 0;
            m_flag   = 1;
            if (m_mode == 2'b01) m_ldpend = 1;
            else                 m_en     = 0;
        end else if (m_ldpend) begin
            m_ldpend   = 0;
            m_count    = m_preset;
            m_flag     = 0;
            m_counting = 1;
        end else if (m_counting) begin
            if (!m_en) begin
                m_counting = 0;
            end else if (m_count > 1) begin
                m_count = m_count - 1;
            end else begin
                m_count    = 0;
                m_counting = 0;
                m_expire   = 1;
            end
        end else if (m_en) begin
            m_ldpend = 1;
        end
        if (w && a == 2'd0) begin
            m_en   = d[0];
            m_mode = d[2:1];
            m_im   = d[3];
            m_flag = 0;
        end
        if (w && a == 2'd1) m_preset = d;
    endtask

    task automatic cycle(bit rst_n, bit w, logic [1:0] a, logic [31:0] d);
        reset     = rst_n;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        model_step(rst_n, w, a, d);
        #1;
        check_value("irq", {31'b0, bus.irq}, {31'b0, m_im & m_flag});
        check_value($sformatf("rdata_a%0d", a), bus.rdata, model_read(a));
    endtask

    initial begin
        int pulses;
        bit w;
        logic [1:0] a;
        logic [31:0] d;

        // Reset
        cycle(0, 0, 2'd0, 0);
        cycle(0, 0, 2'd2, 0);
        check_value("rst_count", bus.rdata, 32'd0);
        check_value("rst_irq", {31'b0, bus.irq}, 32'd0);
        cycle(1, 0, 2'd1, 0);
        check_value("rst_preset", bus.rdata, 32'd0);

        // One-shot, PRESET=3, IM set
        cycle(1, 1, 2'd1, 32'd3);
        cycle(1, 1, 2'd0, 32'h9);
        for (int i = 1; i <= 6; i++) cycle(1, 0, 2'd2, 0);
        check_value("oneshot_irq", {31'b0, bus.irq}, 32'd1);
        cycle(1, 0, 2'd0, 0);
        check_value("oneshot_ctrl", bus.rdata, 32'h8);
        check_value("oneshot_irq_hold", {31'b0, bus.irq}, 32'd1);
        cycle(1, 1, 2'd0, 32'h8);
        check_value("oneshot_clear", {31'b0, bus.irq}, 32'd0);

        // Auto-reload, PRESET=2: one pulse every 4 cycles
        cycle(1, 1, 2'd1, 32'd2);
        cycle(1, 1, 2'd0, 32'hB);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 0, 2'd2, 0);
            if (bus.irq) pulses++;
        end
        check_value("reload_pulses", pulses, 32'd3);
        cycle(1, 0, 2'd0, 0);
        check_value("reload_ctrl", bus.rdata, 32'hB);
        // Reset in the middle of the run
        cycle(1, 1, 2'd1, 32'd6);
        for (int i = 0; i < 5; i++) cycle(1, 0, 2'd2, 0);
        cycle(0, 0, 2'd0, 0);
        check_value("midrst_ctrl", bus.rdata, 32'd0);
        check_value("midrst_irq", {31'b0, bus.irq}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 2'd2, 0);
            if (bus.irq) pulses++;
        end
        check_value("midrst_nopulse", pulses, 32'd0);

        // Masked one-shot, PRESET=1
        cycle(1, 1, 2'd1, 32'd1);
        cycle(1, 1, 2'd0, 32'h1);
        for (int i = 0; i < 8; i++) cycle(1, 0, 2'd0, 0);
        cycle(1, 1, 2'd0, 32'h8);
        cycle(1, 0, 2'd0, 0);
        check_value("masked_irq", {31'b0, bus.irq}, 32'd0);
        cycle(1, 1, 2'd0, 32'h1);
        for (int i = 0; i < 8; i++) cycle(1, 0, 2'd2, 0);
        cycle(1, 1, 2'd1, 32'd4);
        cycle(1, 0, 2'd0, 0);
        check_value("masked_preset_wr", {31'b0, bus.irq}, 32'd0);

        // Mid-count disable, PRESET=10
        cycle(1, 1, 2'd1, 32'd10);
        cycle(1, 1, 2'd0, 32'h1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 2'd2, 0);
        check_value("dis_before", bus.rdata, 32'd6);
        cycle(1, 1, 2'd0, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 2'd2, 0);
        check_value("dis_frozen", bus.rdata, 32'd5);
        cycle(1, 1, 2'd0, 32'h1);
        cycle(1, 0, 2'd2, 0);
        cycle(1, 0, 2'd2, 0);
        check_value("dis_reload", bus.rdata, 32'd10);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            w = ($urandom_range(0, 3) == 0);
            a = 2'($urandom_range(0, 3));
            d = (a == 2'd1) ? $urandom_range(0, 8) : $urandom;
            cycle(($urandom_range(0, 199) != 0), w, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
